// File: rtl/spi_embed_slave_if.sv
// Bus-side signal bundle of the embed-mode loader: the loader drives the bus cycle,
// the memory/peripheral side answers it.
`timescale 1ns/1ps
interface spi_embed_slave_if #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 16
);
   // Handshake: cyc/stb high with we/adr/dat/sel held stable until ack or err is
   // sampled high on a rising clk edge; responders answer only while cyc is high.
   logic              o_wb_cyc;
   logic              o_wb_stb;
   logic              o_wb_we;
   logic [ADDR_W-1:0] o_wb_adr;
   logic [DATA_W-1:0] o_wb_dat;
   logic [1:0]        o_wb_sel;
   logic [DATA_W-1:0] i_wb_dat;
   logic              i_wb_ack;
   logic              i_wb_err;

   modport master (
      output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel,
      input  i_wb_dat, i_wb_ack, i_wb_err
   );

   modport slave (
      input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel,
      output i_wb_dat, i_wb_ack, i_wb_err
   );
endinterface

// File: rtl/spi_embed_slave.sv
// Serial embed-mode loader: turns start/address/we/data frames from an external
// master into single bus cycles and reports completion (and read data) on miso.
`timescale 1ns/1ps
module spi_embed_slave #(
   parameter int ADDR_W      = 24,
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_en,
   input  logic               i_spi_clk,
   input  logic               i_spi_mosi,
   output logic               o_spi_miso,
   spi_embed_slave_if.master  wb,
   output logic               o_bus_err,
   output logic [2:0]         dbg_state
);

   localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int CNT_W = $clog2(MAX_W) + 1;
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, ADDR, WE, DATA, BUS, DONE, RDATA} state_t;

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sclk_d;
   logic                   sclk_s;
   logic                   mosi_s;
   logic                   fall;
   logic                   rise;

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [ADDR_W-1:0] adr, adr_n;
   logic [DATA_W-1:0] dat, dat_n;
   logic [DATA_W-1:0] rdata, rdata_n;
   logic              we, we_n;
   logic              cyc, cyc_n;
   logic              miso, miso_n;
   logic              bus_err, bus_err_n;
   logic [TMO_W-1:0]  tmo, tmo_n;

   // mosi idles high, so its synchroniser resets to 1 to avoid a phantom start bit
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sclk_sync <= '0;
         mosi_sync <= '1;
         sclk_d    <= 1'b0;
      end else begin
         sclk_sync <= SYNC_STAGES'({sclk_sync, i_spi_clk});
         mosi_sync <= SYNC_STAGES'({mosi_sync, i_spi_mosi});
         sclk_d    <= sclk_s;
      end
   end

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];
   assign fall   = sclk_d & ~sclk_s;
   assign rise   = ~sclk_d & sclk_s;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         adr     <= '0;
         dat     <= '0;
         rdata   <= '1;
         we      <= 1'b0;
         cyc     <= 1'b0;
         miso    <= 1'b1;
         bus_err <= 1'b0;
         tmo     <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         adr     <= adr_n;
         dat     <= dat_n;
         rdata   <= rdata_n;
         we      <= we_n;
         cyc     <= cyc_n;
         miso    <= miso_n;
         bus_err <= bus_err_n;
         tmo     <= tmo_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      adr_n     = adr;
      dat_n     = dat;
      rdata_n   = rdata;
      we_n      = we;
      cyc_n     = cyc;
      miso_n    = miso;
      bus_err_n = 1'b0;
      tmo_n     = tmo;
      case (state)
         IDLE: begin
            if (rise) miso_n = 1'b1;
            if (fall && !mosi_s && i_en) begin
               state_n = ADDR;
               cnt_n   = '0;
            end
         end
         ADDR: begin
            if (!i_en) begin
               state_n = IDLE;
               miso_n  = 1'b1;
               cnt_n   = '0;
            end else if (fall) begin
               // right shift with MSB insertion lands the first (LSB) bit at bit 0
               adr_n = {mosi_s, adr[ADDR_W-1:1]};
               if (cnt == ADDR_LAST) begin
                  state_n = WE;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         WE: begin
            if (!i_en) begin
               state_n = IDLE;
               miso_n  = 1'b1;
               cnt_n   = '0;
            end else if (fall) begin
               we_n = mosi_s;
               if (mosi_s) begin
                  state_n = DATA;
                  cnt_n   = '0;
               end else begin
                  state_n = BUS;
                  cyc_n   = 1'b1;
                  tmo_n   = '0;
               end
            end
         end
         DATA: begin
            if (!i_en) begin
               state_n = IDLE;
               miso_n  = 1'b1;
               cnt_n   = '0;
            end else if (fall) begin
               dat_n = {mosi_s, dat[DATA_W-1:1]};
               if (cnt == DATA_LAST) begin
                  state_n = BUS;
                  cyc_n   = 1'b1;
                  tmo_n   = '0;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         BUS: begin
            tmo_n = tmo + 1'b1;
            // err wins over a simultaneous ack; an ack in the last allowed cycle still counts
            if (wb.i_wb_err || (!wb.i_wb_ack && tmo == TMO_LAST)) begin
               cyc_n     = 1'b0;
               bus_err_n = 1'b1;
               rdata_n   = '1;
               state_n   = i_en ? DONE : IDLE;
            end else if (wb.i_wb_ack) begin
               cyc_n = 1'b0;
               if (!we) rdata_n = wb.i_wb_dat;
               state_n = i_en ? DONE : IDLE;
            end
         end
         DONE: begin
            if (rise) begin
               miso_n = 1'b0;
            end else if (fall && !miso) begin
               cnt_n = '0;
               if (we) state_n = IDLE;
               else    state_n = RDATA;
            end
         end
         RDATA: begin
            if (!i_en) begin
               state_n = IDLE;
               miso_n  = 1'b1;
               cnt_n   = '0;
            end else if (rise) begin
               miso_n  = rdata[0];
               rdata_n = {1'b1, rdata[DATA_W-1:1]};
            end else if (fall) begin
               if (cnt == DATA_LAST) begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            cyc_n   = 1'b0;
            miso_n  = 1'b1;
         end
      endcase
   end

   assign wb.o_wb_cyc = cyc;
   assign wb.o_wb_stb = cyc;
   assign wb.o_wb_we  = we;
   assign wb.o_wb_adr = adr;
   assign wb.o_wb_dat = dat;
   assign wb.o_wb_sel = {2{cyc}};
   assign o_spi_miso  = miso;
   assign o_bus_err   = bus_err;
   assign dbg_state   = state;

endmodule

// File: tb/tb_spi_embed_slave.sv
// Bench for spi_embed_slave: bit-banged serial master, bus responder, and a
// scoreboard that checks every bus cycle against the frames that were sent.
`timescale 1ns/1ps
module tb_spi_embed_slave;
   localparam int ADDR_W  = 24;
   localparam int DATA_W  = 16;
   localparam int HALF    = 50;
   localparam int TIMEOUT = 255;

   // clock / reset block
   logic i_clk   = 1'b0;
   logic i_rst_n = 1'b0;
   logic i_en    = 1'b0;
   logic sclk    = 1'b1;
   logic mosi    = 1'b1;
   logic miso;
   logic bus_err;
   logic [2:0] dbg_state;

   always #5 i_clk = ~i_clk;

   spi_embed_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   spi_embed_slave #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2), .TIMEOUT(TIMEOUT)
   ) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_en       (i_en),
      .i_spi_clk  (sclk),
      .i_spi_mosi (mosi),
      .o_spi_miso (miso),
      .wb         (bus),
      .o_bus_err  (bus_err),
      .dbg_state  (dbg_state)
   );

   int n_cmp = 0;
   int n_err = 0;

   // scoreboard entries: {we, adr, dat}
   logic [40:0] exp_q[$];
   int n_cyc      = 0;
   int cur_len    = 0;
   int last_len   = 0;
   int err_pulses = 0;
   int busy_cnt   = 0;
   int resp_mode  = 1;
   int resp_delay = 3;
   logic [15:0] resp_data = 16'h0000;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // bus responder: acks on the resp_delay-th cycle of cyc, or never when resp_mode is 0
   int wait_n = 0;
   always @(negedge i_clk) begin
      bus.i_wb_err = 1'b0;
      bus.i_wb_dat = resp_data;
      if (!bus.o_wb_cyc) begin
         bus.i_wb_ack = 1'b0;
         wait_n = 0;
      end else begin
         wait_n++;
         bus.i_wb_ack = (resp_mode == 1 && wait_n == resp_delay);
      end
   end

   // monitor: pops one expected entry at the start of every bus cycle
   logic cyc_prev = 1'b0;
   logic [40:0] mon_e;
   always @(negedge i_clk) begin
      if (bus.o_wb_cyc && !cyc_prev) begin
         n_cyc++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_cycle: adr %0h with no expected entry", bus.o_wb_adr);
         end else begin
            mon_e = exp_q.pop_front();
            check("bus_we",  64'(bus.o_wb_we),  64'(mon_e[40]));
            check("bus_adr", 64'(bus.o_wb_adr), 64'(mon_e[39:16]));
            if (mon_e[40]) check("bus_dat", 64'(bus.o_wb_dat), 64'(mon_e[15:0]));
            check("bus_sel", 64'(bus.o_wb_sel), 64'(2'b11));
            check("bus_stb", 64'(bus.o_wb_stb), 64'(1'b1));
         end
      end
      if (bus.o_wb_cyc) cur_len++;
      else if (cyc_prev) begin
         last_len = cur_len;
         cur_len  = 0;
      end
      if (bus_err) err_pulses++;
      cyc_prev = bus.o_wb_cyc;
   end

   // driver tasks
   task automatic spi_bit(input logic b);
      mosi = b;
      #HALF sclk = 1'b0;
      #HALF sclk = 1'b1;
   endtask

   task automatic send_frame(input logic we, input logic [23:0] adr, input logic [15:0] dat);
      spi_bit(1'b0);
      for (int i = 0; i < ADDR_W; i++) spi_bit(adr[i]);
      spi_bit(we);
      if (we) for (int i = 0; i < DATA_W; i++) spi_bit(dat[i]);
   endtask

   task automatic wait_done(input string name);
      logic seen;
      int guard;
      seen = 1'b0;
      guard = 0;
      busy_cnt = 0;
      while (!seen && guard < 400) begin
         mosi = 1'b1;
         #HALF;
         if (miso === 1'b0) seen = 1'b1;
         else busy_cnt++;
         sclk = 1'b0;
         #HALF sclk = 1'b1;
         guard++;
      end
      check({name, "_done"}, 64'(seen), 64'(1'b1));
   endtask

   task automatic read_bits(output logic [15:0] rd);
      for (int i = 0; i < DATA_W; i++) begin
         mosi = 1'b1;
         #HALF;
         rd[i] = miso;
         sclk = 1'b0;
         #HALF sclk = 1'b1;
      end
   endtask

   task automatic idle_check(input string name);
      mosi = 1'b1;
      #HALF;
      check({name, "_miso_idle"}, 64'(miso), 64'(1'b1));
      check({name, "_state_idle"}, 64'(dbg_state), 64'(3'd0));
   endtask

   task automatic do_write(input string name, input logic [23:0] adr, input logic [15:0] dat,
                           input logic chk_idle);
      exp_q.push_back({1'b1, adr, dat});
      send_frame(1'b1, adr, dat);
      wait_done(name);
      if (chk_idle) idle_check(name);
   endtask

   task automatic do_read(input string name, input logic [23:0] adr, input logic [15:0] exp);
      logic [15:0] rd;
      exp_q.push_back({1'b0, adr, 16'h0000});
      send_frame(1'b0, adr, 16'h0000);
      wait_done(name);
      read_bits(rd);
      check({name, "_rdata"}, 64'(rd), 64'(exp));
      idle_check(name);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      int e0;
      logic [23:0] a;
      logic [15:0] d;
      repeat (5) @(negedge i_clk);
      check("rst_miso",  64'(miso),           64'(1'b1));
      check("rst_cyc",   64'(bus.o_wb_cyc),   64'(1'b0));
      check("rst_stb",   64'(bus.o_wb_stb),   64'(1'b0));
      check("rst_we",    64'(bus.o_wb_we),    64'(1'b0));
      check("rst_adr",   64'(bus.o_wb_adr),   64'(24'h0));
      check("rst_dat",   64'(bus.o_wb_dat),   64'(16'h0));
      check("rst_sel",   64'(bus.o_wb_sel),   64'(2'b00));
      check("rst_err",   64'(bus_err),        64'(1'b0));
      check("rst_state", 64'(dbg_state),      64'(3'd0));
      i_rst_n = 1'b1;
      i_en    = 1'b1;
      repeat (5) @(negedge i_clk);

      // single write, acked on the third cycle
      resp_mode = 1;
      do_write("wr1", 24'h800021, 16'h3888, 1'b1);
      check("wr1_cyc_len", 64'(last_len), 64'(3));

      // single read returning 0x0004
      resp_data = 16'h0004;
      do_read("rd1", 24'h800024, 16'h0004);

      // no response: timeout on a read, then on a write
      resp_mode = 0;
      e0 = err_pulses;
      do_read("to_rd", 24'h000100, 16'hFFFF);
      check("to_rd_cyc_len", 64'(last_len), 64'(TIMEOUT));
      check("to_rd_err_pulse", 64'(err_pulses - e0), 64'(1));
      check("to_rd_busy_seen", 64'(busy_cnt > 0), 64'(1'b1));
      e0 = err_pulses;
      do_write("to_wr", 24'h000200, 16'h1234, 1'b1);
      check("to_wr_cyc_len", 64'(last_len), 64'(TIMEOUT));
      check("to_wr_err_pulse", 64'(err_pulses - e0), 64'(1));

      // two init clocks then 36 back-to-back writes
      resp_mode = 1;
      resp_delay = 2;
      spi_bit(1'b1);
      spi_bit(1'b1);
      n0 = n_cyc;
      for (int i = 0; i < 36; i++) begin
         a = 24'h100000 + 24'(i * 3);
         d = 16'hA5A5 ^ 16'(i * 16'h0111);
         do_write("b2b", a, d, 1'b0);
      end
      idle_check("b2b_end");
      check("b2b_cycles", 64'(n_cyc - n0), 64'(36));
      check("b2b_queue", 64'(exp_q.size()), 64'(0));

      // enable dropped after 10 address bits
      n0 = n_cyc;
      spi_bit(1'b0);
      for (int i = 0; i < 10; i++) spi_bit(i[0]);
      @(negedge i_clk);
      i_en = 1'b0;
      repeat (4) @(negedge i_clk);
      check("en_abort_state", 64'(dbg_state), 64'(3'd0));
      check("en_abort_miso",  64'(miso),      64'(1'b1));
      for (int i = 0; i < 3; i++) spi_bit(1'b0);
      check("en_low_ignored", 64'(dbg_state), 64'(3'd0));
      i_en = 1'b1;
      repeat (2) @(negedge i_clk);
      check("en_no_cycle", 64'(n_cyc - n0), 64'(0));
      do_write("en_wr", 24'h00ABCD, 16'hBEEF, 1'b1);

      // reset while the bus cycle is outstanding
      resp_mode = 0;
      exp_q.push_back({1'b1, 24'h123456, 16'hCAFE});
      send_frame(1'b1, 24'h123456, 16'hCAFE);
      for (int i = 0; i < 50 && !bus.o_wb_cyc; i++) @(negedge i_clk);
      check("rst_bus_cyc_seen", 64'(bus.o_wb_cyc), 64'(1'b1));
      @(negedge i_clk);
      i_rst_n = 1'b0;
      #1;
      check("rst_bus_cyc",   64'(bus.o_wb_cyc), 64'(1'b0));
      check("rst_bus_stb",   64'(bus.o_wb_stb), 64'(1'b0));
      check("rst_bus_miso",  64'(miso),         64'(1'b1));
      check("rst_bus_state", 64'(dbg_state),    64'(3'd0));
      repeat (3) @(negedge i_clk);
      i_rst_n = 1'b1;
      resp_mode = 1;
      resp_delay = 3;
      repeat (3) @(negedge i_clk);
      do_write("post_rst_wr", 24'h654321, 16'h0F0F, 1'b1);

      repeat (10) @(negedge i_clk);
      check("final_queue_empty", 64'(exp_q.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/spi_embed_slave.md
Name: spi_embed_slave

Overview:
- SPI-style serial slave used in embed mode to load and inspect memory through the design's 16-bit Wishbone-style bus while the core is held disabled.
- Deserialises start/address/direction/data frames from the external master and issues one bus cycle per frame.
- Reports completion on miso. Reads return 16 data bits serially after completion.
- It is the device-side end of the external loader protocol and lives in the top-level wrapper next to the GPIO pin mux.

Parameters:
- ADDR_W, 24: address field width; bits sent LSB first.
- DATA_W, 16: data field width; bits sent LSB first.
- SYNC_STAGES, 2: flip-flop stages synchronising spi_clk and mosi into i_clk.
- TIMEOUT, 255: i_clk cycles to wait for ack/err before the bus cycle is aborted as an error.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous active-low reset
- i_en  input  1  embed mode enable; frames are ignored while low
- i_spi_clk  input  1  serial clock from the pin (asynchronous to i_clk)
- i_spi_mosi  input  1  serial data in; idles high
- o_spi_miso  output  1  1 = idle/busy, 0 = done; carries read data during the read phase
- o_wb_cyc  output  1  bus cycle
- o_wb_stb  output  1  bus strobe
- o_wb_we  output  1  1 = write
- o_wb_adr  output  ADDR_W  bus address
- o_wb_dat  output  DATA_W  write data
- o_wb_sel  output  2  byte select; always 2'b11 during a cycle
- i_wb_dat  input  DATA_W  read data
- i_wb_ack  input  1  bus acknowledge
- i_wb_err  input  1  bus error
- o_bus_err  output  1  one-cycle pulse on bus error or timeout

Behaviour:
- Synchronisation: i_spi_clk and i_spi_mosi each pass through SYNC_STAGES flops. A third flop on the clock path gives edge detect.
  - fall = synced clk 1→0; rise = synced clk 0→1.
  - mosi is sampled only on fall.
  - miso changes only on rise.
  - The master's half-period must be at least 2 i_clk.
- Reset values: o_spi_miso=1; o_wb_cyc, o_wb_stb, o_wb_we, o_bus_err all 0; o_wb_adr=0; o_wb_dat=0; o_wb_sel=0; FSM in IDLE; bit counter 0.
- Frame format: start bit 0, ADDR_W address bits, 1 we bit, then DATA_W data bits only when we=1. The master then clocks with mosi=1 until miso=0, plus one final clock.
- FSM states: IDLE, ADDR, WE, DATA, BUS, DONE, RDATA.
- IDLE:
  - A fall with mosi=0 and i_en=1 → ADDR, counter cleared.
  - Falls with mosi=1 are ignored, which covers the master's init clocks.
- ADDR: shift the sampled bit into adr[cnt]. After ADDR_W bits → WE.
- WE:
  - Sampled bit 1 → DATA.
  - Sampled bit 0 → BUS (read).
- DATA: shift bits into dat[cnt]. After DATA_W bits → BUS.
- BUS:
  - Assert cyc, stb and sel=11, with we/adr/dat held stable, starting on the cycle after entry.
  - On i_wb_ack: drop cyc/stb in the same edge; for reads, latch i_wb_dat; → DONE.
  - On i_wb_err, or TIMEOUT cycles with no response: drop cyc/stb, pulse o_bus_err, read data = all ones, → DONE.
  - ack and err together: treated as err.
  - miso stays 1 throughout BUS.
- DONE:
  - miso=0 from the next rise.
  - Write: the next fall after miso=0 → IDLE, and miso returns to 1 at the next rise.
  - Read: the next fall → RDATA.
- RDATA: miso = rdata[cnt] updated on each rise, LSB first. After DATA_W falls → IDLE, miso=1.
- i_en deasserted:
  - In ADDR/WE/DATA/RDATA: abort to IDLE immediately, miso=1, no bus cycle.
  - In BUS: the bus cycle completes, then → IDLE with no DONE phase.
- Asynchronous reset at any point clears all state. Any in-flight cycle is dropped and cyc goes low immediately.
- Counter is log2(max(ADDR_W, DATA_W))+1 bits. A new frame always re-clears it, so there is no wrap-around.
- Exactly one bus cycle per frame. Back-to-back frames are accepted starting with the fall after returning to IDLE.

Test Plan:
- Write frame adr=0x800021, dat=0x3888 → one bus cycle with we=1, adr=0x800021, dat=0x3888, sel=11. Bench acks after 3 cycles → miso=0, then 1 after the final clock.
- Read frame adr=0x800024, bus returns 0x0004 → miso busy, then 0, then serial bits 0,0,1,0,... (LSB first) on 16 clocks; miso=1 afterwards.
- Bus never acks → after 255 cycles o_bus_err pulses for one cycle and cyc drops. A read returns 0xFFFF; a write still completes handshake with miso=0.
- Two init clocks with mosi=1, then 36 back-to-back write frames → 36 bus cycles with matching adr/dat and no extra cycles.
- i_en dropped after 10 address bits → no bus cycle, miso=1. The next full frame with i_en=1 is executed correctly.
- i_rst_n asserted during BUS → cyc/stb low in the same timestep, miso=1. After release, a new write frame works.
